line_drawer_arbiter: RTL and testbench

LINE_DRAWER_ARBITER -- requirements
Module: line_drawer_arbiter

---
 rtl/line_drawer_arbiter_if.sv | 31 +++
 rtl/line_drawer_arbiter.sv | 98 +++++++++
 tb/tb_line_drawer_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_drawer_arbiter_if.sv
// Bus between two line-request clients, the arbiter, and the shared line drawer.
// The slave modport is the arbiter's view; master is the client/drawer side.
interface line_drawer_arbiter_if #(
    parameter int HOR_ACTIVE_PIXELS = 640,
    parameter int VER_ACTIVE_PIXELS = 480
);
    localparam int X_WIDTH = $clog2(HOR_ACTIVE_PIXELS);
    localparam int Y_WIDTH = $clog2(VER_ACTIVE_PIXELS);

    logic [X_WIDTH-1:0] a_x1, a_x2, b_x1, b_x2, ld_x1, ld_x2;
    logic [Y_WIDTH-1:0] a_y1, a_y2, b_y1, b_y2, ld_y1, ld_y2;
    logic               a_start, a_ready, b_start, b_ready;
    logic               ld_start, ld_ready;
    logic [1:0]         ld_owner;

    modport slave (
        input  a_x1, a_y1, a_x2, a_y2, a_start,
        input  b_x1, b_y1, b_x2, b_y2, b_start,
        input  ld_ready,
        output a_ready, b_ready,
        output ld_x1, ld_y1, ld_x2, ld_y2, ld_start, ld_owner
    );

    modport master (
        output a_x1, a_y1, a_x2, a_y2, a_start,
        output b_x1, b_y1, b_x2, b_y2, b_start,
        output ld_ready,
        input  a_ready, b_ready,
        input  ld_x1, ld_y1, ld_x2, ld_y2, ld_start, ld_owner
    );
endinterface

// File: rtl/line_drawer_arbiter.sv
// Round-robin arbiter sharing one line drawer between clients A and B.
// Each client has a one-deep request slot; coordinates are clamped to the screen on capture.
module line_drawer_arbiter #(
    parameter int HOR_ACTIVE_PIXELS = 640,
    parameter int VER_ACTIVE_PIXELS = 480
) (
    input  logic                 clk,
    input  logic                 rst_n,
    line_drawer_arbiter_if.slave bus
);
    localparam int X_WIDTH = $clog2(HOR_ACTIVE_PIXELS);
    localparam int Y_WIDTH = $clog2(VER_ACTIVE_PIXELS);
    localparam logic [X_WIDTH-1:0] X_MAX = X_WIDTH'(HOR_ACTIVE_PIXELS - 1);
    localparam logic [Y_WIDTH-1:0] Y_MAX = Y_WIDTH'(VER_ACTIVE_PIXELS - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t             state;
    logic               pending_a, pending_b;
    logic               last_grant_b;
    logic               win_b;
    logic [X_WIDTH-1:0] slot_x1 [2];
    logic [X_WIDTH-1:0] slot_x2 [2];
    logic [Y_WIDTH-1:0] slot_y1 [2];
    logic [Y_WIDTH-1:0] slot_y2 [2];

    function automatic logic [X_WIDTH-1:0] clamp_x(input logic [X_WIDTH-1:0] v);
        return (v > X_MAX) ? X_MAX : v;
    endfunction

    function automatic logic [Y_WIDTH-1:0] clamp_y(input logic [Y_WIDTH-1:0] v);
        return (v > Y_MAX) ? Y_MAX : v;
    endfunction

    // On a tie the client that was not granted last wins; index 0 is A, 1 is B.
    assign win_b       = pending_b && (!pending_a || !last_grant_b);
    assign bus.a_ready = ~pending_a;
    assign bus.b_ready = ~pending_b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            pending_a    <= 1'b0;
            pending_b    <= 1'b0;
            last_grant_b <= 1'b1;
            bus.ld_start <= 1'b0;
            bus.ld_owner <= 2'b00;
            bus.ld_x1    <= '0;
            bus.ld_y1    <= '0;
            bus.ld_x2    <= '0;
            bus.ld_y2    <= '0;
        end else begin
            if (bus.a_start && !pending_a) begin
                pending_a  <= 1'b1;
                slot_x1[0] <= clamp_x(bus.a_x1);
                slot_y1[0] <= clamp_y(bus.a_y1);
                slot_x2[0] <= clamp_x(bus.a_x2);
                slot_y2[0] <= clamp_y(bus.a_y2);
            end
            if (bus.b_start && !pending_b) begin
                pending_b  <= 1'b1;
                slot_x1[1] <= clamp_x(bus.b_x1);
                slot_y1[1] <= clamp_y(bus.b_y1);
                slot_x2[1] <= clamp_x(bus.b_x2);
                slot_y2[1] <= clamp_y(bus.b_y2);
            end

            // A pending bit stays set until its line completes, so a_ready/b_ready cover in-service too.
            case (state)
                IDLE: begin
                    if (bus.ld_ready && (pending_a || pending_b)) begin
                        bus.ld_x1    <= slot_x1[win_b];
                        bus.ld_y1    <= slot_y1[win_b];
                        bus.ld_x2    <= slot_x2[win_b];
                        bus.ld_y2    <= slot_y2[win_b];
                        bus.ld_start <= 1'b1;
                        bus.ld_owner <= win_b ? 2'b10 : 2'b01;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.ld_start <= 1'b0;
                    state        <= WAIT;
                end
                WAIT: begin
                    if (bus.ld_ready) begin
                        if (bus.ld_owner[0]) pending_a <= 1'b0;
                        if (bus.ld_owner[1]) pending_b <= 1'b0;
                        last_grant_b <= bus.ld_owner[1];
                        bus.ld_owner <= 2'b00;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_line_drawer_arbiter.sv
// Self-checking bench: a transaction-level model of the arbiter is compared every cycle,
// with directed scenarios pinned by literal expectations and a randomized soak.
module tb_line_drawer_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    line_drawer_arbiter_if #(.HOR_ACTIVE_PIXELS(640), .VER_ACTIVE_PIXELS(480)) bus ();

    line_drawer_arbiter #(.HOR_ACTIVE_PIXELS(640), .VER_ACTIVE_PIXELS(480)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: per-client request slots, who is being served, and the last client served.
    bit m_pend [2];
    int m_slot [2][4];
    int m_ld   [4];
    int m_owner;
    bit m_start;
    int m_last;

    function automatic int clampX(input int v);
        return (v >= 640) ? 639 : v;
    endfunction

    function automatic int clampY(input int v);
        return (v >= 480) ? 479 : v;
    endfunction

    task automatic compare(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelUpdate();
        bit cap_a, cap_b;
        int w;
        if (!rst_n) begin
            m_pend  = '{0, 0};
            m_owner = -1;
            m_start = 0;
            m_last  = 1;
            m_ld    = '{0, 0, 0, 0};
            return;
        end
        cap_a = (bus.a_start === 1'b1) && !m_pend[0];
        cap_b = (bus.b_start === 1'b1) && !m_pend[1];
        if (m_owner < 0) begin
            if (bus.ld_ready === 1'b1 && (m_pend[0] || m_pend[1])) begin
                w       = (m_pend[0] && m_pend[1]) ? 1 - m_last : (m_pend[0] ? 0 : 1);
                m_ld    = m_slot[w];
                m_owner = w;
                m_start = 1;
            end
        end else if (m_start) begin
            m_start = 0;
        end else if (bus.ld_ready === 1'b1) begin
            m_pend[m_owner] = 0;
            m_last  = m_owner;
            m_owner = -1;
        end
        if (cap_a) begin
            m_pend[0] = 1;
            m_slot[0] = '{clampX(int'(bus.a_x1)), clampY(int'(bus.a_y1)),
                          clampX(int'(bus.a_x2)), clampY(int'(bus.a_y2))};
        end
        if (cap_b) begin
            m_pend[1] = 1;
            m_slot[1] = '{clampX(int'(bus.b_x1)), clampY(int'(bus.b_y1)),
                          clampX(int'(bus.b_x2)), clampY(int'(bus.b_y2))};
        end
    endtask

    task automatic checkOutput();
        compare("a_ready",  32'(bus.a_ready),  32'(!m_pend[0]));
        compare("b_ready",  32'(bus.b_ready),  32'(!m_pend[1]));
        compare("ld_start", 32'(bus.ld_start), 32'(m_start));
        compare("ld_owner", 32'(bus.ld_owner), (m_owner < 0) ? 32'd0 : 32'(1 << m_owner));
        compare("ld_x1",    32'(bus.ld_x1),    32'(m_ld[0]));
        compare("ld_y1",    32'(bus.ld_y1),    32'(m_ld[1]));
        compare("ld_x2",    32'(bus.ld_x2),    32'(m_ld[2]));
        compare("ld_y2",    32'(bus.ld_y2),    32'(m_ld[3]));
    endtask

    // Inputs are set around the negedge; one call advances exactly one rising edge.
    task automatic step();
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic applyStimulus(input bit a_s, input bit b_s, input bit ldr);
        bus.a_start  = a_s;
        bus.b_start  = b_s;
        bus.ld_ready = ldr;
    endtask

    task automatic setA(input int x1, input int y1, input int x2, input int y2);
        bus.a_x1 = 10'(x1); bus.a_y1 = 9'(y1); bus.a_x2 = 10'(x2); bus.a_y2 = 9'(y2);
    endtask

    task automatic setB(input int x1, input int y1, input int x2, input int y2);
        bus.b_x1 = 10'(x1); bus.b_y1 = 9'(y1); bus.b_x2 = 10'(x2); bus.b_y2 = 9'(y2);
    endtask

    task automatic waitIssue(input string name);
        bit got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            step();
            if (bus.ld_start === 1'b1) got = 1;
        end
        compare({name, " issue seen"}, 32'(got), 32'd1);
    endtask

    task automatic waitIdle(input string name);
        bit got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            step();
            if (bus.ld_owner === 2'b00 && bus.a_ready === 1'b1 && bus.b_ready === 1'b1) got = 1;
        end
        compare({name, " idle reached"}, 32'(got), 32'd1);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int starts;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        applyStimulus(0, 0, 1);
        setA(0, 0, 0, 0);
        setB(0, 0, 0, 0);

        // Reset state and single-request latency.
        doReset();
        compare("reset ld_owner", 32'(bus.ld_owner), 32'd0);
        compare("reset a_ready",  32'(bus.a_ready),  32'd1);
        compare("reset ld_x2",    32'(bus.ld_x2),    32'd0);
        step();
        setA(0, 0, 10, 20);
        applyStimulus(1, 0, 1);
        step();
        compare("single a_ready low", 32'(bus.a_ready), 32'd0);
        applyStimulus(0, 0, 1);
        step();
        compare("single ld_start", 32'(bus.ld_start), 32'd1);
        compare("single ld_x1",    32'(bus.ld_x1),    32'd0);
        compare("single ld_y1",    32'(bus.ld_y1),    32'd0);
        compare("single ld_x2",    32'(bus.ld_x2),    32'd10);
        compare("single ld_y2",    32'(bus.ld_y2),    32'd20);
        compare("single ld_owner", 32'(bus.ld_owner), 32'd1);
        applyStimulus(0, 0, 0);
        for (int i = 0; i < 5; i++) step();
        compare("single busy a_ready", 32'(bus.a_ready), 32'd0);
        applyStimulus(0, 0, 1);
        step();
        compare("single done a_ready", 32'(bus.a_ready), 32'd1);

        // Tie after reset: A first, then B; later ties alternate.
        doReset();
        setA(1, 2, 3, 4);
        setB(5, 6, 7, 8);
        applyStimulus(1, 1, 1);
        step();
        applyStimulus(0, 0, 1);
        waitIssue("tie1");
        compare("tie1 owner", 32'(bus.ld_owner), 32'd1);
        compare("tie1 ld_x1", 32'(bus.ld_x1),    32'd1);
        waitIssue("tie2");
        compare("tie2 owner", 32'(bus.ld_owner), 32'd2);
        compare("tie2 ld_x1", 32'(bus.ld_x1),    32'd5);
        setA(20, 21, 22, 23);
        applyStimulus(1, 0, 1);
        step();
        applyStimulus(0, 0, 1);
        waitIssue("nonowner");
        compare("nonowner owner", 32'(bus.ld_owner), 32'd1);
        compare("nonowner ld_x1", 32'(bus.ld_x1),    32'd20);
        waitIdle("tie");
        applyStimulus(1, 1, 1);
        step();
        applyStimulus(0, 0, 1);
        waitIssue("tie3");
        compare("tie3 owner", 32'(bus.ld_owner), 32'd2);
        waitIssue("tie4");
        compare("tie4 owner", 32'(bus.ld_owner), 32'd1);
        waitIdle("tie4");

        // Ignored restart while pending, with the drawer busy.
        setA(11, 12, 13, 14);
        applyStimulus(1, 0, 0);
        step();
        setA(99, 98, 97, 96);
        step();
        applyStimulus(0, 0, 0);
        step();
        compare("busy no start", 32'(bus.ld_start), 32'd0);
        applyStimulus(0, 0, 1);
        step();
        compare("busy start after ready", 32'(bus.ld_start), 32'd1);
        compare("ignored ld_x1", 32'(bus.ld_x1), 32'd11);
        compare("ignored ld_y2", 32'(bus.ld_y2), 32'd14);
        starts = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.ld_start === 1'b1) starts++;
        end
        compare("ignored extra starts", 32'(starts), 32'd0);

        // Clamp to screen edges.
        setB(1, 2, 700, 500);
        applyStimulus(0, 1, 1);
        step();
        applyStimulus(0, 0, 1);
        waitIssue("clamp");
        compare("clamp ld_x2", 32'(bus.ld_x2), 32'd639);
        compare("clamp ld_y2", 32'(bus.ld_y2), 32'd479);
        compare("clamp ld_x1", 32'(bus.ld_x1), 32'd1);
        waitIdle("clamp");

        // Reset in WAIT drops everything; no issue until the drawer reports ready.
        setA(30, 31, 32, 33);
        applyStimulus(1, 0, 1);
        step();
        applyStimulus(0, 0, 1);
        waitIssue("midreset");
        applyStimulus(0, 0, 0);
        step();
        step();
        setB(40, 41, 42, 43);
        applyStimulus(0, 1, 0);
        step();
        rst_n = 1'b0;
        applyStimulus(1, 1, 0);
        step();
        rst_n = 1'b1;
        compare("midreset owner",   32'(bus.ld_owner), 32'd0);
        compare("midreset a_ready", 32'(bus.a_ready),  32'd1);
        compare("midreset b_ready", 32'(bus.b_ready),  32'd1);
        compare("midreset start",   32'(bus.ld_start), 32'd0);
        setA(50, 51, 52, 53);
        applyStimulus(1, 0, 0);
        step();
        applyStimulus(0, 0, 0);
        starts = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.ld_start === 1'b1) starts++;
        end
        compare("midreset held starts", 32'(starts), 32'd0);
        applyStimulus(0, 0, 1);
        step();
        compare("midreset resume start", 32'(bus.ld_start), 32'd1);
        compare("midreset resume ld_x1", 32'(bus.ld_x1),    32'd50);

        // Randomized soak against the model.
        for (int i = 0; i < 4000; i++) begin
            setA($urandom_range(0, 1023), $urandom_range(0, 511), $urandom_range(0, 1023), $urandom_range(0, 511));
            setB($urandom_range(0, 1023), $urandom_range(0, 511), $urandom_range(0, 1023), $urandom_range(0, 511));
            applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 299) != 0);
            step();
        end
        rst_n = 1'b1;
        applyStimulus(0, 0, 1);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
